// File: rtl/combo_lock_pkg.sv
// Shared types and constants for the two-bit keypad combination lock.
package combo_lock_pkg;

    typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_t;

    typedef logic [1:0] sym_t;

    // 00 is the "no key" encoding from the keypad and never appears in a code
    localparam sym_t SYM_NONE = 2'b00;

    localparam int         DEFAULT_CODE_LEN = 5;
    localparam logic [9:0] DEFAULT_CODE     = 10'b01_10_11_10_01;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/combo_lock_if.sv
// Keypad-side bundle: symbol strobe and clear in, lock status out.
interface combo_lock_if #(
    parameter int MAX_FAIL = 3
);
    import combo_lock_pkg::*;

    localparam int FW = $clog2(MAX_FAIL + 1);

    logic          sym_valid;
    sym_t          sym;
    logic          clear;
    logic          ready;
    logic          led;
    logic          lockout;
    logic [FW-1:0] fail_cnt;

    modport master (
        output sym_valid, sym, clear,
        input  ready, led, lockout, fail_cnt
    );

    modport slave (
        input  sym_valid, sym, clear,
        output ready, led, lockout, fail_cnt
    );

endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter; expired is high during the last counted cycle.
module lock_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign expired = (count == W'(1));

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination lock controller: symbol entry, timed unlock window,
// wrong-attempt counting and timed lockout.
module combo_lock_ctrl
    import combo_lock_pkg::*;
#(
    parameter int                      CODE_LEN    = DEFAULT_CODE_LEN,
    parameter logic [2*CODE_LEN-1:0]   CODE        = DEFAULT_CODE,
    parameter int                      MAX_FAIL    = 3,
    parameter int                      OPEN_CYC    = 8,
    parameter int                      LOCKOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    combo_lock_if.slave bus
);

    localparam int IW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(max_int(OPEN_CYC, LOCKOUT_CYC) + 1);

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic          mism, mism_n;
    logic [FW-1:0] fail_r, fail_n;
    logic          led_r, led_n;
    logic          lock_r, lock_n;
    logic          tmr_load, tmr_expired;
    logic [TW-1:0] tmr_val;
    logic          do_eval, eval_mism;
    logic          sym_miss;

    // Code table padded to a power of two so any index value is in range
    sym_t code_tab [2**IW];

    always_comb begin
        for (int i = 0; i < 2**IW; i++) begin
            int sh;
            sh          = (i < CODE_LEN) ? 2 * (CODE_LEN - 1 - i) : 0;
            code_tab[i] = (i < CODE_LEN) ? sym_t'(CODE >> sh) : SYM_NONE;
        end
    end

    assign sym_miss = (bus.sym != code_tab[idx]) || (bus.sym == SYM_NONE);

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            mism   <= 1'b0;
            fail_r <= '0;
            led_r  <= 1'b0;
            lock_r <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            mism   <= mism_n;
            fail_r <= fail_n;
            led_r  <= led_n;
            lock_r <= lock_n;
        end
    end

    // The last accepted symbol raises do_eval; the verdict is resolved once below
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        mism_n    = mism;
        fail_n    = fail_r;
        led_n     = led_r;
        lock_n    = lock_r;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        do_eval   = 1'b0;
        eval_mism = 1'b0;

        case (state)
            IDLE: begin
                if (bus.sym_valid && !bus.clear) begin
                    if (CODE_LEN == 1) begin
                        do_eval   = 1'b1;
                        eval_mism = sym_miss;
                    end else begin
                        state_n = ENTRY;
                        idx_n   = IW'(1);
                        mism_n  = sym_miss;
                    end
                end
            end
            ENTRY: begin
                if (bus.clear) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    mism_n  = 1'b0;
                end else if (bus.sym_valid) begin
                    if (int'(idx) == CODE_LEN - 1) begin
                        do_eval   = 1'b1;
                        eval_mism = mism | sym_miss;
                    end else begin
                        idx_n  = idx + 1'b1;
                        mism_n = mism | sym_miss;
                    end
                end
            end
            OPEN: begin
                if (bus.clear || tmr_expired) begin
                    state_n = IDLE;
                    led_n   = 1'b0;
                end
            end
            LOCKOUT: begin
                if (tmr_expired) begin
                    state_n = IDLE;
                    lock_n  = 1'b0;
                    fail_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_eval) begin
            idx_n  = '0;
            mism_n = 1'b0;
            if (!eval_mism) begin
                state_n  = OPEN;
                led_n    = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = TW'(OPEN_CYC);
                fail_n   = '0;
            end else if (int'(fail_r) + 1 < MAX_FAIL) begin
                state_n = IDLE;
                fail_n  = fail_r + 1'b1;
            end else begin
                state_n  = LOCKOUT;
                lock_n   = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = TW'(LOCKOUT_CYC);
                fail_n   = FW'(MAX_FAIL);
            end
        end
    end

    assign bus.ready    = (state == IDLE) || (state == ENTRY);
    assign bus.led      = led_r;
    assign bus.lockout  = lock_r;
    assign bus.fail_cnt = fail_r;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl with immediate-assertion checks.
module tb_combo_lock_ctrl;
    import combo_lock_pkg::*;

    localparam logic [9:0] GOOD  = 10'b01_10_11_10_01;
    localparam logic [9:0] BADLAST = 10'b01_10_11_10_10;
    localparam logic [9:0] BADALL  = 10'b11_11_11_11_11;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    combo_lock_if #(.MAX_FAIL(3)) bus ();

    combo_lock_ctrl #(
        .CODE_LEN    (5),
        .CODE        (GOOD),
        .MAX_FAIL    (3),
        .OPEN_CYC    (8),
        .LOCKOUT_CYC (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic rdy, input logic led,
                               input logic lck, input logic [1:0] fc);
        check1({tag, ".ready"},    8'(bus.ready),    8'(rdy));
        check1({tag, ".led"},      8'(bus.led),      8'(led));
        check1({tag, ".lockout"},  8'(bus.lockout),  8'(lck));
        check1({tag, ".fail_cnt"}, 8'(bus.fail_cnt), 8'(fc));
    endtask

    // One clock with the given inputs; outputs are looked at 1ns after the edge
    task automatic applyStimulus(input logic v, input logic [1:0] s, input logic c);
        bus.sym_valid = v;
        bus.sym       = s;
        bus.clear     = c;
        @(posedge clk);
        #1;
        bus.sym_valid = 1'b0;
        bus.sym       = 2'b00;
        bus.clear     = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 1'b0);
    endtask

    task automatic pressCode(input logic [9:0] code, input int gap);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, code[9-2*i -: 2], 1'b0);
            if (i < 4) idleCycles(gap);
        end
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.sym_valid = 1'b0;
        bus.sym       = 2'b00;
        bus.clear     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset", 1'b1, 1'b0, 1'b0, 2'd0);

        $display("[TB] correct code opens for 8 cycles");
        pressCode(GOOD, 0);
        checkOutput("open_c1", 1'b0, 1'b1, 1'b0, 2'd0);
        for (int i = 2; i <= 8; i++) begin
            idleCycles(1);
            check1($sformatf("open_c%0d.led", i), 8'(bus.led), 8'd1);
        end
        idleCycles(1);
        checkOutput("open_end", 1'b1, 1'b0, 1'b0, 2'd0);

        $display("[TB] wrong last symbol then correct code");
        pressCode(BADLAST, 0);
        checkOutput("bad1", 1'b1, 1'b0, 1'b0, 2'd1);
        pressCode(GOOD, 0);
        checkOutput("good_after_bad", 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b0, 2'b00, 1'b1);
        checkOutput("relock_clear", 1'b1, 1'b0, 1'b0, 2'd0);

        $display("[TB] three failures lock out for 16 cycles");
        pressCode(BADALL, 0);
        checkOutput("fail1", 1'b1, 1'b0, 1'b0, 2'd1);
        pressCode(BADALL, 0);
        checkOutput("fail2", 1'b1, 1'b0, 1'b0, 2'd2);
        pressCode(BADALL, 0);
        checkOutput("lock_c1", 1'b0, 1'b0, 1'b1, 2'd3);
        pressCode(GOOD, 0);
        checkOutput("lock_c6", 1'b0, 1'b0, 1'b1, 2'd3);
        applyStimulus(1'b0, 2'b00, 1'b1);
        idleCycles(9);
        checkOutput("lock_c16", 1'b0, 1'b0, 1'b1, 2'd3);
        idleCycles(1);
        checkOutput("lock_end", 1'b1, 1'b0, 1'b0, 2'd0);
        pressCode(GOOD, 0);
        checkOutput("open_after_lock", 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b0, 2'b00, 1'b1);

        $display("[TB] clear mid-entry keeps fail count; gapped entry");
        pressCode(BADLAST, 0);
        applyStimulus(1'b1, 2'b01, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1);
        checkOutput("entry_clear", 1'b1, 1'b0, 1'b0, 2'd1);
        pressCode(GOOD, 3);
        checkOutput("gapped_open", 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b0, 2'b00, 1'b1);

        $display("[TB] clear with last symbol, clear during open");
        applyStimulus(1'b1, 2'b01, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b1);
        checkOutput("clear_wins", 1'b1, 1'b0, 1'b0, 2'd0);
        idleCycles(2);
        check1("clear_wins_hold.led", 8'(bus.led), 8'd0);
        pressCode(GOOD, 0);
        checkOutput("reopen", 1'b0, 1'b1, 1'b0, 2'd0);
        idleCycles(2);
        check1("open_c3.led", 8'(bus.led), 8'd1);
        applyStimulus(1'b0, 2'b00, 1'b1);
        checkOutput("open_clear", 1'b1, 1'b0, 1'b0, 2'd0);

        $display("[TB] reset mid-entry and mid-lockout");
        pressCode(BADLAST, 0);
        applyStimulus(1'b1, 2'b01, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        check1("pre_reset.fail_cnt", 8'(bus.fail_cnt), 8'd1);
        pulseReset();
        checkOutput("reset_entry", 1'b1, 1'b0, 1'b0, 2'd0);
        pressCode(BADALL, 0);
        pressCode(BADALL, 0);
        pressCode(BADALL, 0);
        idleCycles(3);
        checkOutput("pre_reset_lock", 1'b0, 1'b0, 1'b1, 2'd3);
        pulseReset();
        checkOutput("reset_lock", 1'b1, 1'b0, 1'b0, 2'd0);
        pressCode(GOOD, 0);
        checkOutput("open_after_reset", 1'b0, 1'b1, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
